// File: rtl/muldiv_pkg.sv
// Shared decode constants and FSM state type for the EX-stage multiply/divide unit.
package muldiv_pkg;

   localparam logic [1:0] ALUOP_RTYPE = 2'b10;

   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
   localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
   localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
   localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
   localparam logic [5:0] FUNCT_MTLO  = 6'b010011;

   typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} md_state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 shift-add multiplier / restoring divider datapath with iteration counter.
// hi/lo hold the running product, or remainder/quotient when dividing.
module muldiv_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [CNT_W-1:0] cnt
);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   sum, shifted, diff;

   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      shifted = {hi_q, lo_q[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
      hi_d    = hi_q;
      lo_d    = lo_q;
      cnt_d   = cnt_q;
      if (load) begin
         hi_d  = '0;
         lo_d  = op_a;
         cnt_d = CNT_W'(WIDTH);
      end else if (step) begin
         cnt_d = cnt_q - CNT_W'(1);
         if (is_div) begin
            // Borrow out of the trial subtract means the divisor did not fit: restore.
            if (diff[WIDTH]) begin
               hi_d = shifted[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end else begin
               hi_d = diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end
         end else begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         b_q   <= '0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         cnt_q <= cnt_d;
         if (load) b_q <= op_b;
      end
   end

   assign hi  = hi_q;
   assign lo  = lo_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/muldiv_unit.sv
// EX-stage multiply/divide unit: decode, iteration FSM, sign fix-up, HI/LO and stall.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             kill_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic [WIDTH-1:0] mf_data_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   md_state_t          state_q;
   logic               busy_q, div_q, neg_q, rneg_q, divz_q;
   logic [WIDTH-1:0]   hi_q, lo_q, rs_q;
   logic               rtype, is_signed, is_div_op, is_muldiv, is_mf, is_mt, accept, mt_wr;
   logic [WIDTH-1:0]   mag_a, mag_b, it_hi, it_lo, fix_hi, fix_lo;
   logic [2*WIDTH-1:0] prod;
   logic [CNT_W-1:0]   cnt;

   always_comb begin
      rtype     = valid_i & (aluop == ALUOP_RTYPE);
      is_muldiv = rtype & (funct inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU});
      is_mf     = rtype & (funct inside {FUNCT_MFHI, FUNCT_MFLO});
      is_mt     = rtype & (funct inside {FUNCT_MTHI, FUNCT_MTLO});
      is_signed = (funct == FUNCT_MULT) | (funct == FUNCT_DIV);
      is_div_op = (funct == FUNCT_DIV) | (funct == FUNCT_DIVU);
      stall_o   = (is_muldiv | is_mf | is_mt) & busy_q;
      accept    = (state_q == StIdle) & is_muldiv & ~kill_i & ~stall_o;
      mt_wr     = (state_q == StIdle) & is_mt & ~kill_i;
      mag_a     = (is_signed & rs_val[WIDTH-1]) ? -rs_val : rs_val;
      mag_b     = (is_signed & rt_val[WIDTH-1]) ? -rt_val : rt_val;

      prod = {it_hi, it_lo};
      if (neg_q) prod = -prod;
      if (div_q) begin
         // Divide by zero bypasses sign fix and returns the raw dividend.
         if (divz_q) begin
            fix_lo = '1;
            fix_hi = rs_q;
         end else begin
            fix_lo = neg_q ? -it_lo : it_lo;
            fix_hi = rneg_q ? -it_hi : it_hi;
         end
      end else begin
         fix_hi = prod[2*WIDTH-1:WIDTH];
         fix_lo = prod[WIDTH-1:0];
      end

      mf_data_o = '0;
      if (rtype && funct == FUNCT_MFHI) mf_data_o = hi_q;
      else if (rtype && funct == FUNCT_MFLO) mf_data_o = lo_q;
   end

   muldiv_iter #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_iter (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .step   ((state_q == StMul) | (state_q == StDiv)),
      .is_div (state_q == StDiv),
      .op_a   (mag_a),
      .op_b   (mag_b),
      .hi     (it_hi),
      .lo     (it_lo),
      .cnt    (cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         busy_q  <= 1'b0;
         div_q   <= 1'b0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         divz_q  <= 1'b0;
         rs_q    <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  state_q <= is_div_op ? StDiv : StMul;
                  busy_q  <= 1'b1;
                  div_q   <= is_div_op;
                  neg_q   <= is_signed & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  rneg_q  <= is_signed & rs_val[WIDTH-1];
                  divz_q  <= (rt_val == '0);
                  rs_q    <= rs_val;
               end else if (mt_wr) begin
                  if (funct == FUNCT_MTHI) hi_q <= rs_val;
                  else lo_q <= rs_val;
               end
            end
            StMul, StDiv: begin
               if (kill_i) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else if (cnt == CNT_W'(1)) begin
                  state_q <= StFix;
               end
            end
            StFix: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               if (!kill_i) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign hi_o   = hi_q;
   assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at WIDTH=32 plus a WIDTH=8 instance.
module tb_muldiv_unit;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MFHI  = 6'b010000;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MFLO  = 6'b010010;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_ADD   = 6'b100000;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, kill_i;
   logic [1:0]  aluop;
   logic [5:0]  funct;
   logic [31:0] rs_val, rt_val;
   logic        stall_o, busy_o;
   logic [31:0] mf_data_o, hi_o, lo_o;

   logic        valid8, kill8;
   logic [5:0]  funct8;
   logic [7:0]  rs8, rt8;
   logic        stall8, busy8;
   logic [7:0]  mf8, hi8, lo8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid_i),
      .aluop     (aluop),
      .funct     (funct),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .kill_i    (kill_i),
      .stall_o   (stall_o),
      .busy_o    (busy_o),
      .mf_data_o (mf_data_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (valid8),
      .aluop     (aluop),
      .funct     (funct8),
      .rs_val    (rs8),
      .rt_val    (rt8),
      .kill_i    (kill8),
      .stall_o   (stall8),
      .busy_o    (busy8),
      .mf_data_o (mf8),
      .hi_o      (hi8),
      .lo_o      (lo8)
   );

   // Present one instruction for a single edge; returns at the next negedge.
   task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      valid_i = 1'b1;
      funct   = f;
      rs_val  = a;
      rt_val  = b;
      @(negedge clk);
      valid_i = 1'b0;
      funct   = 6'd0;
   endtask

   // Counts cycles with busy_o high, bounded.
   task automatic wait_idle(output int n);
      n = 0;
      #1;
      while (busy_o && n < 200) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy_o); end
      n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %0b want 0", stall_o); end
      n_cmp++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
         n_bad++; $display("FAIL reset_hilo got %h/%h want 0/0", hi_o, lo_o); end
      n_cmp++; if (mf_data_o !== 32'h0) begin n_bad++; $display("FAIL reset_mf got %h want 0", mf_data_o); end
      n_cmp++; if (busy8 !== 1'b0 || hi8 !== 8'h0) begin
         n_bad++; $display("FAIL reset_w8 got busy %0b hi %h want 0/0", busy8, hi8); end
   endtask

   task automatic test_multu_max;
      int n;
      issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_idle(n);
      n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL multu_latency got %0d want 33", n); end
      n_cmp++; if (hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h0000_0001) begin
         n_bad++; $display("FAIL multu_max got %h/%h want fffffffe/00000001", hi_o, lo_o); end
   endtask

   task automatic test_signed;
      int n;
      issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
      wait_idle(n);
      n_cmp++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFEB) begin
         n_bad++; $display("FAIL mult_neg got %h/%h want ffffffff/ffffffeb", hi_o, lo_o); end
      issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL div_latency got %0d want 33", n); end
      n_cmp++; if (hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFFD) begin
         n_bad++; $display("FAIL div_neg got %h/%h want ffffffff/fffffffd", hi_o, lo_o); end
   endtask

   task automatic test_div_special;
      int n;
      issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      n_cmp++; if (hi_o !== 32'h0 || lo_o !== 32'h8000_0000) begin
         n_bad++; $display("FAIL div_minint got %h/%h want 00000000/80000000", hi_o, lo_o); end
      issue(F_DIVU, 32'd5, 32'd0);
      wait_idle(n);
      n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL divz_latency got %0d want 33", n); end
      n_cmp++; if (hi_o !== 32'd5 || lo_o !== 32'hFFFF_FFFF) begin
         n_bad++; $display("FAIL divu_zero got %h/%h want 00000005/ffffffff", hi_o, lo_o); end
      issue(F_DIV, 32'hFFFF_FFFB, 32'd0);
      wait_idle(n);
      n_cmp++; if (hi_o !== 32'hFFFF_FFFB || lo_o !== 32'hFFFF_FFFF) begin
         n_bad++; $display("FAIL div_zero got %h/%h want fffffffb/ffffffff", hi_o, lo_o); end
   endtask

   task automatic test_stall_mf;
      int n;
      int s;
      issue(F_MULTU, 32'h0001_0000, 32'h0003_0003);
      // One cycle after the MULT: present MFLO and hold it.
      @(negedge clk);
      valid_i = 1'b1;
      funct   = F_MFLO;
      s = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (!stall_o) break;
         s++;
         @(negedge clk);
      end
      n_cmp++; if (s !== 32) begin n_bad++; $display("FAIL mf_stall_cycles got %0d want 32", s); end
      n_cmp++; if (mf_data_o !== 32'h0003_0000) begin
         n_bad++; $display("FAIL mf_after_stall got %h want 00030000", mf_data_o); end
      funct = F_MFHI;
      #1;
      n_cmp++; if (mf_data_o !== 32'h0000_0003) begin
         n_bad++; $display("FAIL mfhi got %h want 00000003", mf_data_o); end
      valid_i = 1'b0;
      // An unrelated R-type op in EX never stalls.
      issue(F_MULT, 32'd2, 32'd3);
      valid_i = 1'b1;
      funct   = F_ADD;
      #1;
      n_cmp++; if (stall_o !== 1'b0 || busy_o !== 1'b1) begin
         n_bad++; $display("FAIL add_nostall got stall %0b busy %0b want 0/1", stall_o, busy_o); end
      funct = F_MFHI;
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL mfhi_stall got %0b want 1", stall_o); end
      valid_i = 1'b0;
      wait_idle(n);
      n_cmp++; if (lo_o !== 32'd6 || hi_o !== 32'd0) begin
         n_bad++; $display("FAIL mult_small got %h/%h want 0/6", hi_o, lo_o); end
   endtask

   task automatic test_mt_kill;
      issue(F_MTHI, 32'h1234, 32'h0);
      n_cmp++; if (hi_o !== 32'h1234) begin n_bad++; $display("FAIL mthi got %h want 00001234", hi_o); end
      issue(F_MTLO, 32'h5678, 32'h0);
      n_cmp++; if (lo_o !== 32'h5678) begin n_bad++; $display("FAIL mtlo got %h want 00005678", lo_o); end
      issue(F_MULTU, 32'd1000, 32'd1000);
      repeat (9) @(negedge clk);
      kill_i = 1'b1;
      @(negedge clk);
      kill_i = 1'b0;
      #1;
      n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL kill_busy got %0b want 0", busy_o); end
      repeat (40) @(negedge clk);
      n_cmp++; if (hi_o !== 32'h1234 || lo_o !== 32'h5678) begin
         n_bad++; $display("FAIL kill_hilo got %h/%h want 00001234/00005678", hi_o, lo_o); end
      // Killed decodes in IDLE neither write nor start.
      valid_i = 1'b1;
      funct   = F_MTLO;
      rs_val  = 32'hDEAD;
      kill_i  = 1'b1;
      @(negedge clk);
      funct = F_MULT;
      @(negedge clk);
      valid_i = 1'b0;
      kill_i  = 1'b0;
      #1;
      n_cmp++; if (lo_o !== 32'h5678 || busy_o !== 1'b0) begin
         n_bad++; $display("FAIL kill_idle got lo %h busy %0b want 00005678/0", lo_o, busy_o); end
   endtask

   task automatic test_back_to_back;
      int n;
      int s;
      issue(F_MULTU, 32'd3, 32'd5);
      valid_i = 1'b1;
      funct   = F_DIVU;
      rs_val  = 32'd100;
      rt_val  = 32'd7;
      s = 0;
      for (int i = 0; i < 60; i++) begin
         #1;
         if (!stall_o) break;
         s++;
         @(negedge clk);
      end
      n_cmp++; if (s !== 33) begin n_bad++; $display("FAIL b2b_stall got %0d want 33", s); end
      n_cmp++; if (lo_o !== 32'd15 || hi_o !== 32'd0) begin
         n_bad++; $display("FAIL b2b_first got %h/%h want 0/f", hi_o, lo_o); end
      @(negedge clk);
      valid_i = 1'b0;
      funct   = 6'd0;
      wait_idle(n);
      n_cmp++; if (n !== 33) begin n_bad++; $display("FAIL b2b_second_busy got %0d want 33", n); end
      n_cmp++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin
         n_bad++; $display("FAIL b2b_divu got %h/%h want 2/e", hi_o, lo_o); end
   endtask

   task automatic test_reset_mid;
      int n;
      issue(F_DIV, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst    = 1'b1;
      kill_i = 1'b1;
      @(negedge clk);
      rst    = 1'b0;
      kill_i = 1'b0;
      #1;
      n_cmp++; if (busy_o !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
         n_bad++; $display("FAIL rst_mid got busy %0b hi %h lo %h want 0/0/0", busy_o, hi_o, lo_o); end
      // WIDTH=8 instance.
      @(negedge clk);
      valid8 = 1'b1;
      funct8 = F_MULTU;
      rs8    = 8'hFF;
      rt8    = 8'hFF;
      @(negedge clk);
      valid8 = 1'b0;
      n = 0;
      #1;
      while (busy8 && n < 50) begin
         n++;
         @(negedge clk);
         #1;
      end
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL w8_latency got %0d want 9", n); end
      n_cmp++; if (hi8 !== 8'hFE || lo8 !== 8'h01) begin
         n_bad++; $display("FAIL w8_multu got %h/%h want fe/01", hi8, lo8); end
   endtask

   initial begin
      rst     = 1'b1;
      valid_i = 1'b0;
      kill_i  = 1'b0;
      aluop   = 2'b10;
      funct   = 6'd0;
      rs_val  = '0;
      rt_val  = '0;
      valid8  = 1'b0;
      kill8   = 1'b0;
      funct8  = 6'd0;
      rs8     = '0;
      rt8     = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      test_reset;
      test_multu_max;
      test_signed;
      test_div_special;
      test_stall_mf;
      test_mt_kill;
      test_back_to_back;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
